// File: rtl/core_run_monitor.sv
// Run-control monitor: counts RUN cycles and retirements, keeps a circular trace of
// recently retired PCs, and ends the run on a same-PC halt loop or a cycle timeout.
module core_run_monitor #(
   parameter int PC_W     = 32,
   parameter int DEPTH    = 16,
   parameter int TIMEOUT  = 1000,
   parameter int HALT_CNT = 4,
   parameter int CNT_W    = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic [PC_W-1:0]          i_pc_debug,
   input  logic                     i_insn_vld,
   input  logic [$clog2(DEPTH)-1:0] i_trace_idx,
   output logic [PC_W-1:0]          o_trace_pc,
   output logic                     o_trace_vld,
   output logic [1:0]               o_state,
   output logic                     o_done,
   output logic [CNT_W-1:0]         o_insn_cnt,
   output logic [CNT_W-1:0]         o_cycle_cnt
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int FILL_W = IDX_W + 1;
   localparam int SAME_W = $clog2(HALT_CNT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_TMO  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  insn_cnt;
   logic [IDX_W-1:0]  wptr;
   logic [FILL_W-1:0] fill;
   logic [SAME_W-1:0] same_cnt;
   logic              last_vld;
   logic [PC_W-1:0]   last_pc;
   logic [PC_W-1:0]   trace_mem [DEPTH];

   logic              run_step;
   logic              retire;
   logic              arm;
   logic              halt_hit;
   logic              tmo_hit;
   logic [CNT_W-1:0]  cycle_nxt;
   logic [SAME_W-1:0] same_nxt;
   logic [IDX_W-1:0]  rd_ptr;

   // The same-PC count only has to reach HALT_CNT, so it saturates there.
   function automatic logic [SAME_W-1:0] sat_inc_same(input logic [SAME_W-1:0] v);
      return (v == SAME_W'(HALT_CNT)) ? v : v + SAME_W'(1);
   endfunction

   always_comb begin
      run_step  = (state == S_RUN) && i_en;
      retire    = run_step && i_insn_vld;
      arm       = (state == S_IDLE) && i_en;
      cycle_nxt = cycle_cnt + CNT_W'(1);
      same_nxt  = (last_vld && (i_pc_debug == last_pc)) ? sat_inc_same(same_cnt) : SAME_W'(1);
      halt_hit  = retire && (same_nxt == SAME_W'(HALT_CNT));
      tmo_hit   = run_step && (cycle_nxt == CNT_W'(TIMEOUT));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Dropping i_en wins over everything; halt wins over a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_en) state_nxt = S_RUN;
         S_RUN: begin
            if (!i_en)        state_nxt = S_IDLE;
            else if (halt_hit) state_nxt = S_HALT;
            else if (tmo_hit)  state_nxt = S_TMO;
         end
         default: if (!i_en) state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_state     = state;
      o_done      = (state == S_HALT) || (state == S_TMO);
      o_insn_cnt  = insn_cnt;
      o_cycle_cnt = cycle_cnt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         cycle_cnt <= '0;
         insn_cnt  <= '0;
         wptr      <= '0;
         fill      <= '0;
         same_cnt  <= '0;
         last_vld  <= 1'b0;
      end else if (arm) begin
         cycle_cnt <= '0;
         insn_cnt  <= '0;
         wptr      <= '0;
         fill      <= '0;
         same_cnt  <= '0;
         last_vld  <= 1'b0;
      end else if (run_step) begin
         cycle_cnt <= cycle_nxt;
         if (i_insn_vld) begin
            insn_cnt <= insn_cnt + CNT_W'(1);
            wptr     <= wptr + IDX_W'(1);
            if (fill != FILL_W'(DEPTH)) fill <= fill + FILL_W'(1);
            same_cnt <= same_nxt;
            last_vld <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (retire) begin
         trace_mem[wptr] <= i_pc_debug;
         last_pc         <= i_pc_debug;
      end
   end

   // Unfilled entries are never written since reset, so the read is gated to 0.
   always_comb begin
      rd_ptr      = wptr - IDX_W'(1) - i_trace_idx;
      o_trace_vld = ({1'b0, i_trace_idx} < fill);
      o_trace_pc  = o_trace_vld ? trace_mem[rd_ptr] : '0;
   end
endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based behavioural model.
module tb_core_run_monitor;
   localparam int PC_W     = 32;
   localparam int DEPTH    = 16;
   localparam int TIMEOUT  = 50;
   localparam int HALT_CNT = 4;
   localparam int CNT_W    = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic [PC_W-1:0]  pc = '0;
   logic             insn_vld = 1'b0;
   logic [3:0]       trace_idx = '0;
   logic [PC_W-1:0]  trace_pc;
   logic             trace_vld;
   logic [1:0]       state;
   logic             done;
   logic [CNT_W-1:0] insn_cnt;
   logic [CNT_W-1:0] cycle_cnt;

   int n_vec = 0;
   int n_err = 0;

   core_run_monitor #(
      .PC_W(PC_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .HALT_CNT(HALT_CNT), .CNT_W(CNT_W)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_pc_debug(pc), .i_insn_vld(insn_vld),
      .i_trace_idx(trace_idx), .o_trace_pc(trace_pc), .o_trace_vld(trace_vld),
      .o_state(state), .o_done(done), .o_insn_cnt(insn_cnt), .o_cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: run history as a queue, newest retirement at index 0.
   logic [PC_W-1:0] pcq[$];
   int m_state = 0;
   int m_cyc   = 0;
   int m_insn  = 0;

   function automatic bit last_n_equal();
      if (pcq.size() < HALT_CNT) return 1'b0;
      for (int k = 1; k < HALT_CNT; k++)
         if (pcq[k] != pcq[0]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_state = 0; m_cyc = 0; m_insn = 0; pcq.delete();
      end else begin
         case (m_state)
            0: if (en) begin
               m_state = 1; m_cyc = 0; m_insn = 0; pcq.delete();
            end
            1: if (!en) m_state = 0;
               else begin
                  bit hit;
                  hit = 1'b0;
                  m_cyc++;
                  if (insn_vld) begin
                     m_insn++;
                     pcq.push_front(pc);
                     if (pcq.size() > DEPTH) void'(pcq.pop_back());
                     hit = last_n_equal();
                  end
                  if (hit) m_state = 2;
                  else if (m_cyc == TIMEOUT) m_state = 3;
               end
            default: if (!en) m_state = 0;
         endcase
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("model_state", state, m_state);
         check("model_done", done, (m_state >= 2));
         check("model_insn", insn_cnt, m_insn);
         check("model_cycle", cycle_cnt, m_cyc);
         check("model_tvld", trace_vld, (int'(trace_idx) < pcq.size()));
         check("trace_pc_known", $isunknown(trace_pc), 0);
         if (int'(trace_idx) < pcq.size()) check("model_tpc", trace_pc, pcq[trace_idx]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      rst_n = 1'b0; en = 1'b0; insn_vld = 1'b0;
      step();
      rst_n = 1'b1; en = 1'b1;
      step();
   endtask

   task automatic expect_trace(input int idx, input bit exp_vld, input logic [PC_W-1:0] exp_pc);
      trace_idx = 4'(idx);
      #1;
      check($sformatf("trace_vld[%0d]", idx), trace_vld, exp_vld);
      if (exp_vld) check($sformatf("trace_pc[%0d]", idx), trace_pc, exp_pc);
      step();
   endtask

   initial begin
      logic [PC_W-1:0] halt_seq [6];
      halt_seq = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};

      // Reset held two cycles, then arm with no retirements.
      step(); step();
      check("rst_state", state, 0);
      check("rst_done", done, 0);
      check("rst_cycle", cycle_cnt, 0);
      check("rst_insn", insn_cnt, 0);
      check("rst_tvld", trace_vld, 0);
      rst_n = 1'b1; en = 1'b1;
      step();
      check("arm_state", state, 1);
      check("arm_cycle0", cycle_cnt, 0);
      step(); step(); step();
      check("arm_cycle3", cycle_cnt, 3);
      check("arm_insn", insn_cnt, 0);
      expect_trace(0, 0, '0);
      expect_trace(15, 0, '0);

      // Halt on four retirements at 0x8.
      arm();
      for (int i = 0; i < 6; i++) begin
         pc = halt_seq[i]; insn_vld = 1'b1;
         step();
      end
      insn_vld = 1'b0;
      check("halt_state", state, 2);
      check("halt_done", done, 1);
      check("halt_insn", insn_cnt, 6);
      check("halt_cycle", cycle_cnt, 6);
      for (int i = 0; i < 4; i++) expect_trace(i, 1, 32'h8);
      expect_trace(4, 1, 32'h4);
      expect_trace(5, 1, 32'h0);
      expect_trace(6, 0, '0);
      en = 1'b0;
      step();
      check("idle_state", state, 0);
      check("idle_keep_insn", insn_cnt, 6);
      check("idle_keep_cycle", cycle_cnt, 6);
      expect_trace(0, 1, 32'h8);
      en = 1'b1;
      step();
      check("rearm_state", state, 1);
      check("rearm_insn", insn_cnt, 0);
      check("rearm_cycle", cycle_cnt, 0);
      expect_trace(0, 0, '0);

      // Trace wrap: 20 distinct PCs into 16 entries.
      arm();
      for (int i = 0; i < 20; i++) begin
         pc = 32'(i * 4); insn_vld = 1'b1;
         step();
      end
      insn_vld = 1'b0;
      check("wrap_insn", insn_cnt, 20);
      expect_trace(0, 1, 32'h4C);
      expect_trace(8, 1, 32'h2C);
      expect_trace(15, 1, 32'h10);
      en = 1'b0;
      step();

      // Timeout with retirements every other cycle.
      arm();
      for (int i = 0; i < TIMEOUT; i++) begin
         pc = 32'h100 + 32'(i * 4); insn_vld = (i % 2 == 0);
         step();
      end
      check("tmo_state", state, 3);
      check("tmo_done", done, 1);
      check("tmo_cycle", cycle_cnt, 50);
      check("tmo_insn", insn_cnt, 25);
      for (int i = 0; i < 4; i++) begin
         pc = 32'h300 + 32'(i * 4); insn_vld = 1'b1;
         step();
      end
      insn_vld = 1'b0;
      check("tmo_frozen_insn", insn_cnt, 25);
      check("tmo_frozen_cycle", cycle_cnt, 50);
      check("tmo_sticky", state, 3);
      en = 1'b0;
      step();

      // Halt and timeout on the same cycle: halt wins.
      arm();
      for (int i = 0; i < TIMEOUT; i++) begin
         pc = 32'h200; insn_vld = (i >= TIMEOUT - HALT_CNT);
         step();
      end
      insn_vld = 1'b0;
      check("simul_state", state, 2);
      check("simul_cycle", cycle_cnt, 50);
      check("simul_insn", insn_cnt, 4);
      en = 1'b0;
      step();

      // Reset in the middle of a run.
      arm();
      for (int i = 0; i < 7; i++) begin
         pc = 32'h40 + 32'(i * 4); insn_vld = 1'b1;
         step();
      end
      check("mid_insn", insn_cnt, 7);
      check("mid_state", state, 1);
      rst_n = 1'b0;
      step();
      insn_vld = 1'b0;
      check("mid_rst_state", state, 0);
      check("mid_rst_insn", insn_cnt, 0);
      check("mid_rst_cycle", cycle_cnt, 0);
      expect_trace(0, 0, '0);
      rst_n = 1'b1; en = 1'b0;
      step();

      // Randomized phase against the model.
      begin
         bit wide;
         wide = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) wide = ($urandom_range(0, 2) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if (!en) en = ($urandom_range(0, 3) == 0);
            else     en = ($urandom_range(0, 39) != 0);
            insn_vld  = ($urandom_range(0, 1) == 1);
            pc        = wide ? 32'($urandom_range(0, 31)) << 2 : 32'($urandom_range(0, 1)) << 2;
            trace_idx = 4'($urandom_range(0, 15));
            step();
         end
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/core_run_monitor.md
Name: core_run_monitor

Overview:
Synthesizable run-control monitor that watches a core's debug PC and instruction-valid strobe. Counts cycles and retired instructions, records the last DEPTH retired PCs in a circular trace buffer, and ends the run on halt (self-loop at one PC) or on a cycle timeout. Replaces fixed-delay run termination with a parametrised, observable end-of-run condition, usable beside the core on FPGA or in simulation.

Parameters:
PC_W, 32, width of observed PC and trace entries
DEPTH, 16, trace buffer entries; power of 2, >= 2
TIMEOUT, 1000, RUN cycles before timeout; >= 2
HALT_CNT, 4, consecutive retirements at the same PC that declare halt; >= 2
CNT_W, 32, width of cycle and instruction counters

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_en  in  1  arm; 1 = run monitoring, 0 = return to IDLE
i_pc_debug  in  PC_W  PC of the instruction retiring this cycle
i_insn_vld  in  1  retirement strobe for i_pc_debug
i_trace_idx  in  $clog2(DEPTH)  trace read index; 0 = most recent retirement
o_trace_pc  out  PC_W  trace entry at i_trace_idx (combinational read)
o_trace_vld  out  1  1 when i_trace_idx < number of entries filled
o_state  out  2  0 IDLE, 1 RUN, 2 HALT, 3 TIMEOUT
o_done  out  1  state is HALT or TIMEOUT
o_insn_cnt  out  CNT_W  retirements counted in RUN
o_cycle_cnt  out  CNT_W  cycles spent in RUN

Behaviour:
- Reset (i_rst_n=0 at a rising edge): state IDLE; counters, write pointer, fill count, same-PC count, last-PC valid flag all 0. o_state=0, o_done=0, o_trace_vld=0. o_trace_pc must not be X (clear the buffer, or gate the output to 0 when o_trace_vld=0). Reset overrides all other events, including mid-run.
- IDLE: all state held. If i_en=1, go to RUN next edge and clear counters, trace fill, write pointer and same-PC tracking on that same edge. Values from the previous run stay readable until re-arm.
- RUN, every cycle: cycle_cnt += 1. If i_insn_vld=1:
  - insn_cnt += 1
  - buf[wptr] <= i_pc_debug; wptr += 1 mod DEPTH; fill saturates at DEPTH (oldest entry overwritten)
  - same-PC count <= (last valid and i_pc_debug == last_pc) ? count+1 (saturating) : 1; last_pc <= i_pc_debug; last valid <= 1
- Halt: in RUN, if i_insn_vld=1 and the updated same-PC count == HALT_CNT, go to HALT next edge. The halting retirement is counted and traced.
- Timeout: in RUN, if the updated cycle_cnt == TIMEOUT, go to TIMEOUT.
- If halt and timeout occur on the same cycle, HALT wins.
- HALT and TIMEOUT are sticky. Counters and trace are frozen; retirements are ignored.
- i_en=0 in RUN, HALT or TIMEOUT: go to IDLE next edge; counters and trace are preserved.
- Trace read: o_trace_pc = buf[(wptr - 1 - i_trace_idx) mod DEPTH]; o_trace_vld = (i_trace_idx < fill). Pure combinational from registered state.
- Counters wrap modulo 2^CNT_W (requires CNT_W > $clog2(TIMEOUT)).
- Latency: every register update becomes visible one edge after the sampled input.

Test Plan:
- Reset/arm: reset held 2 cycles, then i_en=1 with no retirements -> o_state goes 0 then 1; o_cycle_cnt reads 1, 2, 3…; o_insn_cnt=0; o_trace_vld=0 for every index.
- Halt: retire PCs 0x0, 0x4, 0x8, then 0x8 three more times back-to-back (HALT_CNT=4) -> o_state=2 and o_done=1 on the edge after the 6th retirement; o_insn_cnt=6; idx0..3 read 0x8, idx4=0x4, idx5=0x0, idx6 o_trace_vld=0.
- Wrap: DEPTH=16, retire PCs 0x0, 0x4, …, 0x4C (20 distinct values) -> fill=16; idx0=0x4C, idx15=0x10, all indices valid; o_insn_cnt=20.
- Timeout: TIMEOUT=50, retire distinct PCs every other cycle -> o_state=3 once o_cycle_cnt=50; o_insn_cnt=25; further i_insn_vld pulses change nothing.
- Simultaneous: TIMEOUT=50 with the HALT_CNT-th same-PC retirement landing on cycle 50 -> o_state=2, not 3.
- Reset mid-run and re-arm: i_rst_n=0 during RUN with o_insn_cnt=7 -> state IDLE and all counts 0 next edge. Separately, drop i_en in HALT, then re-raise it -> IDLE keeps the previous counts, re-arm clears them to 0.
